// File: rtl/secboot_pkg.sv
// Shared types and constants for the secure-boot signature sequencer.
package secboot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_REPORT,
        ST_LOCKED
    } state_e;

    localparam int N_PK_W   = 8;
    localparam int N_SIG_W  = 16;
    localparam int N_HASH_W = 8;
    localparam int N_TOT_W  = N_PK_W + N_SIG_W + N_HASH_W;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_FRAME   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/secboot_wdt.sv
// WAIT-state watchdog: counts enabled cycles since the last clear and flags the LIMIT-th one.
module secboot_wdt #(
    parameter int unsigned LIMIT = 4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(LIMIT) + 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && !expire_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q holds the number of enabled cycles already completed
    assign expire_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/secboot_verify_seq.sv
// Secure-boot signature sequencer: loads pk/sig/hash words, starts the verifier, keeps a sticky verdict.
// Define SECBOOT_TIMEOUT_EN to bound the WAIT state with a watchdog of TIMEOUT_CYC cycles.
//
//  state  | meaning
//  IDLE   | waiting for req_i
//  LOAD   | accepting the 32-word operand stream
//  START  | one-cycle verifier start pulse
//  WAIT   | waiting for verifier done (or watchdog expiry)
//  REPORT | one-cycle done pulse, choose IDLE or LOCKED
//  LOCKED | boot path locked after failure, left only by reset
module secboot_verify_seq #(
    parameter int unsigned TIMEOUT_CYC  = 4096,
    parameter bit          LOCK_ON_FAIL = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [31:0]  s_data_i,
    input  logic         s_last_i,
    output logic         vfy_start_o,
    output logic [255:0] vfy_pubkey_o,
    output logic [511:0] vfy_sig_o,
    output logic [255:0] vfy_hash_o,
    input  logic         vfy_done_i,
    input  logic         vfy_ok_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         pass_o,
    output logic         fail_o,
    output logic [1:0]   err_code_o,
    output logic         locked_o
);
    import secboot_pkg::*;

    localparam int PK_LO   = 0;
    localparam int SIG_LO  = N_PK_W * 32;
    localparam int HASH_LO = (N_PK_W + N_SIG_W) * 32;
    localparam int OP_W    = N_TOT_W * 32;

    state_e          state_q, state_d;
    logic [4:0]      idx_q;
    logic [OP_W-1:0] op_q;
    logic            pass_q, fail_q;
    logic [1:0]      err_q;
    logic            hs, frame_err, wdt_expire;

    assign hs        = s_valid_i && (state_q == ST_LOAD);
    assign frame_err = hs && (s_last_i != (idx_q == 5'(N_TOT_W - 1)));

`ifdef SECBOOT_TIMEOUT_EN
    secboot_wdt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (state_q == ST_START),
        .en_i     (state_q == ST_WAIT),
        .expire_o (wdt_expire)
    );
`else
    assign wdt_expire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_i) state_d = ST_LOAD;
            ST_LOAD: begin
                if (frame_err) begin
                    state_d = ST_REPORT;
                end else if (hs && (idx_q == 5'(N_TOT_W - 1))) begin
                    state_d = ST_START;
                end
            end
            ST_START:  state_d = ST_WAIT;
            ST_WAIT:   if (vfy_done_i || wdt_expire) state_d = ST_REPORT;
            ST_REPORT: state_d = (fail_q && LOCK_ON_FAIL) ? ST_LOCKED : ST_IDLE;
            ST_LOCKED: state_d = ST_LOCKED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            op_q   <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            err_q  <= ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        idx_q  <= '0;
                        op_q   <= '0;
                        pass_q <= 1'b0;
                        fail_q <= 1'b0;
                        err_q  <= ERR_NONE;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        op_q[{idx_q, 5'b0} +: 32] <= s_data_i;
                        idx_q <= idx_q + 1'b1;
                        if (frame_err) begin
                            err_q  <= ERR_FRAME;
                            fail_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    // a done in the expiry cycle still yields the real verdict
                    if (vfy_done_i) begin
                        pass_q <= vfy_ok_i;
                        fail_q <= !vfy_ok_i;
                    end else if (wdt_expire) begin
                        err_q  <= ERR_TIMEOUT;
                        fail_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_ready_o    = (state_q == ST_LOAD);
    assign vfy_start_o  = (state_q == ST_START);
    assign done_o       = (state_q == ST_REPORT);
    assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_LOCKED);
    assign locked_o     = (state_q == ST_LOCKED);
    assign pass_o       = pass_q;
    assign fail_o       = fail_q;
    assign err_code_o   = err_q;
    assign vfy_pubkey_o = op_q[PK_LO   +: N_PK_W*32];
    assign vfy_sig_o    = op_q[SIG_LO  +: N_SIG_W*32];
    assign vfy_hash_o   = op_q[HASH_LO +: N_HASH_W*32];

endmodule

// File: tb/tb_secboot_verify_seq.sv
// Scoreboard bench for secboot_verify_seq: a locking (dut) and a non-locking (dut_nl) instance share stimulus.
module tb_secboot_verify_seq;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         req_i = 1'b0;
    logic         s_valid_i = 1'b0;
    logic [31:0]  s_data_i = '0;
    logic         s_last_i = 1'b0;
    logic         vfy_done_i = 1'b0;
    logic         vfy_ok_i = 1'b0;

    logic         s_ready, vfy_start, busy, done, pass, fail, locked;
    logic [255:0] pk, hash;
    logic [511:0] sig;
    logic [1:0]   err;

    logic         s_ready_nl, vfy_start_nl, busy_nl, done_nl, pass_nl, fail_nl, locked_nl;
    logic [255:0] pk_nl, hash_nl;
    logic [511:0] sig_nl;
    logic [1:0]   err_nl;

    always #5 clk_i = ~clk_i;

    secboot_verify_seq #(.TIMEOUT_CYC(16), .LOCK_ON_FAIL(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .vfy_start_o(vfy_start), .vfy_pubkey_o(pk), .vfy_sig_o(sig), .vfy_hash_o(hash),
        .vfy_done_i(vfy_done_i), .vfy_ok_i(vfy_ok_i),
        .busy_o(busy), .done_o(done), .pass_o(pass), .fail_o(fail),
        .err_code_o(err), .locked_o(locked)
    );

    secboot_verify_seq #(.TIMEOUT_CYC(16), .LOCK_ON_FAIL(1'b0)) dut_nl (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_nl), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .vfy_start_o(vfy_start_nl), .vfy_pubkey_o(pk_nl), .vfy_sig_o(sig_nl), .vfy_hash_o(hash_nl),
        .vfy_done_i(vfy_done_i), .vfy_ok_i(vfy_ok_i),
        .busy_o(busy_nl), .done_o(done_nl), .pass_o(pass_nl), .fail_o(fail_nl),
        .err_code_o(err_nl), .locked_o(locked_nl)
    );

    typedef struct {
        logic         pass;
        logic         fail;
        logic [1:0]   err;
        logic         lock;
        int           nstart;
        int           lat;
        bit           chk_op;
        logic [1023:0] ops;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] img[32];
    int          vfy_delay = 1;
    bit          vfy_never = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1023:0] pack_img();
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[k*32 +: 32] = img[k];
        return r;
    endfunction

    task automatic set_uniform(input logic [31:0] p, input logic [31:0] s, input logic [31:0] h);
        for (int k = 0; k < 32; k++) img[k] = (k < 8) ? p : (k < 24) ? s : h;
    endtask

    task automatic expect_session(input logic p, input logic f, input logic [1:0] e,
                                  input logic lk, input int ns, input int lat, input bit chk_op);
        exp_t x;
        x.pass = p; x.fail = f; x.err = e; x.lock = lk;
        x.nstart = ns; x.lat = lat; x.chk_op = chk_op; x.ops = pack_img();
        sb_q.push_back(x);
    endtask

    // verifier model: ok = (sig[255:0] ^ pk) == hash, done vfy_delay cycles after start
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && vfy_start && !vfy_never) begin
                repeat (vfy_delay) @(negedge clk_i);
                vfy_ok_i   = ((sig[255:0] ^ pk) == hash);
                vfy_done_i = 1'b1;
                @(negedge clk_i);
                vfy_done_i = 1'b0;
                vfy_ok_i   = 1'b0;
            end
        end
    end

    // monitor: pops one expectation per done_o pulse
    initial begin
        int   cyc = 0;
        int   nstart = 0;
        int   t_start = 0;
        exp_t x;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_ni) begin
                nstart = 0;
            end else begin
                if (vfy_start) begin
                    nstart++;
                    t_start = cyc;
                end
                if (done) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done_o=1 expected no session end");
                    end else begin
                        x = sb_q.pop_front();
                        chk("pass", pass, x.pass);
                        chk("fail", fail, x.fail);
                        chk("err_code", err, x.err);
                        chk("locked_next", (x.fail && x.lock), x.lock);
                        chk("start_count", nstart, x.nstart);
                        if (x.lat >= 0) chk("start_to_done", cyc - t_start, x.lat);
                        chk("nl_done", done_nl, 1'b1);
                        chk("nl_pass", pass_nl, x.pass);
                        chk("nl_fail", fail_nl, x.fail);
                        chk("nl_err_code", err_nl, x.err);
                        if (x.chk_op) begin
                            checks++;
                            if ({hash, sig, pk} !== x.ops) begin
                                errors++;
                                for (int k = 0; k < 32; k++) begin
                                    logic [1023:0] a;
                                    a = {hash, sig, pk};
                                    if (a[k*32 +: 32] !== x.ops[k*32 +: 32]) begin
                                        $display("FAIL operands: word %0d got %h expected %h",
                                                 k, a[k*32 +: 32], x.ops[k*32 +: 32]);
                                        break;
                                    end
                                end
                            end
                        end
                    end
                    nstart = 0;
                end
            end
        end
    end

    task automatic do_reset();
        rst_ni = 1'b0;
        req_i = 1'b0; s_valid_i = 1'b0; s_last_i = 1'b0; vfy_never = 1'b0; vfy_delay = 1;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic start_session();
        @(negedge clk_i);
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input logic last);
        bit ok = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = last;
        for (int n = 0; n < 100; n++) begin
            if (s_ready) begin
                @(posedge clk_i);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk_i);
            #1;
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake: got s_ready_o=0 for 100 cycles expected 1");
        end
    endtask

    task automatic send_image(input int n_words, input int last_at, input bit gaps, input bit req_noise);
        for (int i = 0; i < n_words; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) begin
                    if (req_noise) req_i = 1'($urandom_range(0, 1));
                    @(posedge clk_i);
                    #1;
                end
            end
            if (req_noise) req_i = 1'($urandom_range(0, 1));
            push_word(img[i], (i == last_at));
        end
        req_i = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got no done_o in 200 cycles expected a pulse");
        end
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        do_reset();
        rst_ni = 1'b0;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", s_ready, 1'b0);
        chk("rst_status", {pass, fail, err, locked, done, vfy_start}, '0);
        chk("rst_operands", |{hash, sig, pk}, 1'b0);
        do_reset();

        // good image, done one cycle after start
        set_uniform(32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        expect_session(1'b1, 1'b0, 2'd0, 1'b0, 1, 2, 1'b1);
        start_session();
        send_image(32, 31, 1'b0, 1'b0);
        wait_done();
        chk("t1_locked", locked, 1'b0);
        chk("t1_busy", busy, 1'b0);

        // distinct words, random gaps, stray req_i in LOAD and WAIT
        for (int k = 0; k < 8; k++)  img[k] = 32'h1000_0000 + k;
        for (int k = 8; k < 24; k++) img[k] = 32'h2000_0100 + k;
        for (int k = 0; k < 8; k++)  img[24 + k] = img[k] ^ img[8 + k];
        vfy_delay = 5;
        expect_session(1'b1, 1'b0, 2'd0, 1'b0, 1, 6, 1'b1);
        start_session();
        send_image(32, 31, 1'b1, 1'b1);
        req_i = 1'b1;
        repeat (2) begin @(posedge clk_i); #1; end
        req_i = 1'b0;
        wait_done();
        repeat (4) @(negedge clk_i);
        chk("t6_busy_after", busy, 1'b0);

        // bad hash: locking instance locks, non-locking returns to IDLE
        vfy_delay = 1;
        set_uniform(32'h1111_1111, 32'h2222_2222, 32'h0000_0000);
        expect_session(1'b0, 1'b1, 2'd0, 1'b1, 1, 2, 1'b1);
        start_session();
        send_image(32, 31, 1'b0, 1'b0);
        wait_done();
        chk("t2_locked", locked, 1'b1);
        chk("t2_nl_locked", locked_nl, 1'b0);
        chk("t2_nl_busy", busy_nl, 1'b0);
        start_session();
        @(negedge clk_i);
        chk("t2_busy_after_req", busy, 1'b0);
        chk("t2_still_locked", locked, 1'b1);
        chk("t2_nl_busy_after_req", busy_nl, 1'b1);

        // framing: s_last_i on word 10
        do_reset();
        set_uniform(32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        expect_session(1'b0, 1'b1, 2'd1, 1'b1, 0, -1, 1'b0);
        start_session();
        send_image(11, 10, 1'b0, 1'b0);
        wait_done();
        chk("t3a_locked", locked, 1'b1);
        chk("t3a_nl_busy", busy_nl, 1'b0);

        // framing: no s_last_i on word 31
        do_reset();
        expect_session(1'b0, 1'b1, 2'd1, 1'b1, 0, -1, 1'b0);
        start_session();
        send_image(32, -1, 1'b0, 1'b0);
        wait_done();
        chk("t3b_locked", locked, 1'b1);

        // reset after 12 words, then a clean good image
        do_reset();
        for (int k = 0; k < 32; k++) img[k] = 32'hDEAD_0000 + k;
        start_session();
        send_image(12, -1, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #2;
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_ready", s_ready, 1'b0);
        chk("t5_rst_status", {pass, fail, err, locked, done, vfy_start}, '0);
        chk("t5_rst_operands", |{hash, sig, pk}, 1'b0);
        do_reset();
        set_uniform(32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        expect_session(1'b1, 1'b0, 2'd0, 1'b0, 1, 2, 1'b1);
        start_session();
        send_image(32, 31, 1'b0, 1'b0);
        wait_done();

`ifdef SECBOOT_TIMEOUT_EN
        // verifier never answers: 16 WAIT cycles then timeout
        do_reset();
        vfy_never = 1'b1;
        expect_session(1'b0, 1'b1, 2'd2, 1'b1, 1, 17, 1'b1);
        start_session();
        send_image(32, 31, 1'b0, 1'b0);
        wait_done();
        chk("t4_locked", locked, 1'b1);
        // done in the expiry cycle wins
        do_reset();
        vfy_delay = 16;
        expect_session(1'b1, 1'b0, 2'd0, 1'b0, 1, 17, 1'b1);
        start_session();
        send_image(32, 31, 1'b0, 1'b0);
        wait_done();
`else
        // without the watchdog WAIT holds indefinitely
        do_reset();
        vfy_never = 1'b1;
        start_session();
        send_image(32, 31, 1'b0, 1'b0);
        repeat (60) @(negedge clk_i);
        chk("t4_wait_busy", busy, 1'b1);
        chk("t4_wait_err", err, 2'd0);
        do_reset();
`endif

        repeat (3) @(negedge clk_i);
        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
